// File: rtl/sc_spil_txbuf.sv
// First-word-fall-through transmit buffer for the SPI engine, NUM_OF_BUF words deep.
// Define SC_SPIL_TXBUF_ERRFLAG_EN to build the sticky OVF/UDF error flags.
module sc_spil_txbuf #(
  parameter int unsigned NUM_OF_BUF = 1,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              CLR,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              RD_REQ,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic [3:0]        TXDPT,
  output logic              FULL,
  output logic              EMPTY,
  output logic              OVF,
  output logic              UDF
);

  localparam int unsigned       PTR_W    = (NUM_OF_BUF > 1) ? $clog2(NUM_OF_BUF) : 1;
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(NUM_OF_BUF - 1);
  localparam logic [3:0]        LVL_MAX  = 4'(NUM_OF_BUF);

  logic [DATA_W-1:0] r_mem [NUM_OF_BUF];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [3:0]        r_level;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_level == LVL_MAX);
  assign w_empty = (r_level == '0);
  // A push into a full buffer is legal when the same cycle pops a word.
  assign w_pop   = RD_REQ & ~w_empty;
  assign w_push  = WR_EN & (~w_full | RD_REQ);

  always_ff @(posedge HCLK) begin
    if (w_push && !CLR) begin
      r_mem[r_wptr] <= WR_DATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (CLR) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= f_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_inc(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 4'd1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 4'd1;
      end
    end
  end

`ifdef SC_SPIL_TXBUF_ERRFLAG_EN
  logic r_ovf;
  logic r_udf;

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (CLR) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (WR_EN && w_full && !RD_REQ) begin
        r_ovf <= 1'b1;
      end
      if (RD_REQ && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign OVF = r_ovf;
  assign UDF = r_udf;
`else
  assign OVF = 1'b0;
  assign UDF = 1'b0;
`endif

  assign RD_DATA  = r_mem[r_rptr];
  assign RD_VALID = ~w_empty;
  assign TXDPT    = r_level;
  assign FULL     = w_full;
  assign EMPTY    = w_empty;

endmodule
